// File: rtl/phase_scan_sequencer.sv
// ---------------------------------------------------------------------------
// phase_scan_sequencer
//
// Sweeps the calibration-phase trigger FSM through a series of phase shifts.
// For each of step_count steps it drives fsm_phase_shift, issues
// shots_per_step start pulses, and waits for every trigger pulse to finish
// (rise then fall of trigger_in) before moving on.
//
// Ports:
//   clock            system clock
//   reset_signal     synchronous, active-high reset (highest priority)
//   scan_start       rising edge launches a scan (ignored while busy)
//   scan_abort       level; returns a running scan to IDLE
//   shift_begin      phase shift of step 0
//   shift_step       phase increment per step (wraps modulo 2^SHIFT_W)
//   step_count       number of steps (0 = finish immediately)
//   shots_per_step   start pulses per step (0 treated as 1)
//   trigger_in       output_trigger of the calibration FSM
//   fsm_start        start_signal to the calibration FSM
//   fsm_phase_shift  phase_shift to the calibration FSM
//   busy             high in every state except IDLE
//   done             sticky scan-complete flag
//   timeout_err      sticky shot-timeout flag
//   cur_step         index of the current step
//   cur_shot         index of the current shot within the step
//   scenario_state   zero-extended state code
// ---------------------------------------------------------------------------
module phase_scan_sequencer #(
    parameter int unsigned SHIFT_W         = 32,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned START_PULSE_LEN = 4,
    parameter int unsigned SHOT_TIMEOUT    = 20_000_000
) (
    input  logic               clock,
    input  logic               reset_signal,
    input  logic               scan_start,
    input  logic               scan_abort,
    input  logic [SHIFT_W-1:0] shift_begin,
    input  logic [SHIFT_W-1:0] shift_step,
    input  logic [CNT_W-1:0]   step_count,
    input  logic [CNT_W-1:0]   shots_per_step,
    input  logic               trigger_in,
    output logic               fsm_start,
    output logic [SHIFT_W-1:0] fsm_phase_shift,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   cur_step,
    output logic [CNT_W-1:0]   cur_shot,
    output logic [7:0]         scenario_state
);

    // One spare bit so the counter can run one past the limit in WAIT_END
    // (edge wins over timeout) without wrapping.
    localparam int unsigned TMO_W = $clog2(SHOT_TIMEOUT) + 1;
    localparam int unsigned ARM_W = $clog2(START_PULSE_LEN + 1);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(SHOT_TIMEOUT);
    localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(START_PULSE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ARM       = 3'd2,
        S_WAIT_TRIG = 3'd3,
        S_WAIT_END  = 3'd4,
        S_NEXT      = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t             state_q;
    logic [1:0]         start_hist_q;
    logic [1:0]         trig_hist_q;
    logic [SHIFT_W-1:0] step_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   shots_q;
    logic [ARM_W-1:0]   arm_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               fsm_start_q;
    logic [SHIFT_W-1:0] phase_q;
    logic               done_q;
    logic               tmo_err_q;
    logic [CNT_W-1:0]   cur_step_q;
    logic [CNT_W-1:0]   cur_shot_q;

    logic               start_rise_d;
    logic               trig_rise_d;
    logic               trig_fall_d;
    logic [TMO_W-1:0]   tmo_inc_d;
    logic               tmo_hit_d;
    logic [CNT_W:0]     shot_inc_d;
    logic [CNT_W:0]     step_inc_d;

    assign start_rise_d = (start_hist_q == 2'b01);
    assign trig_rise_d  = (trig_hist_q == 2'b01);
    assign trig_fall_d  = (trig_hist_q == 2'b10);
    assign tmo_inc_d    = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    assign tmo_hit_d    = (tmo_inc_d >= TMO_LIMIT);
    // Index increments are one bit wider so the "+1 < limit" tests cannot wrap.
    assign shot_inc_d   = {1'b0, cur_shot_q} + {{CNT_W{1'b0}}, 1'b1};
    assign step_inc_d   = {1'b0, cur_step_q} + {{CNT_W{1'b0}}, 1'b1};

    // Scan sequencing FSM, edge histories, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset_signal) begin
            state_q      <= S_IDLE;
            start_hist_q <= 2'b00;
            trig_hist_q  <= 2'b00;
            step_q       <= '0;
            count_q      <= '0;
            shots_q      <= '0;
            arm_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            fsm_start_q  <= 1'b0;
            phase_q      <= '0;
            done_q       <= 1'b0;
            tmo_err_q    <= 1'b0;
            cur_step_q   <= '0;
            cur_shot_q   <= '0;
        end else begin
            start_hist_q <= {start_hist_q[0], scan_start};
            trig_hist_q  <= {trig_hist_q[0], trigger_in};

            if (scan_abort && (state_q != S_IDLE)) begin
                // Abort keeps indices, phase and sticky flags as they were.
                state_q     <= S_IDLE;
                fsm_start_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_rise_d) begin
                            done_q    <= 1'b0;
                            tmo_err_q <= 1'b0;
                            state_q   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        step_q     <= shift_step;
                        count_q    <= step_count;
                        shots_q    <= (shots_per_step == '0) ?
                                      {{(CNT_W-1){1'b0}}, 1'b1} : shots_per_step;
                        phase_q    <= shift_begin;
                        cur_step_q <= '0;
                        cur_shot_q <= '0;
                        if (step_count == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            fsm_start_q <= 1'b1;
                            arm_cnt_q   <= '0;
                            state_q     <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        if (arm_cnt_q == ARM_LAST) begin
                            fsm_start_q <= 1'b0;
                            tmo_cnt_q   <= '0;
                            state_q     <= S_WAIT_TRIG;
                        end else begin
                            arm_cnt_q <= arm_cnt_q + {{(ARM_W-1){1'b0}}, 1'b1};
                        end
                    end
                    S_WAIT_TRIG: begin
                        tmo_cnt_q <= tmo_inc_d;
                        if (trig_rise_d) begin
                            state_q <= S_WAIT_END;
                        end else if (tmo_hit_d) begin
                            tmo_err_q <= 1'b1;
                            state_q   <= S_ERROR;
                        end
                    end
                    S_WAIT_END: begin
                        tmo_cnt_q <= tmo_inc_d;
                        if (trig_fall_d) begin
                            state_q <= S_NEXT;
                        end else if (tmo_hit_d) begin
                            tmo_err_q <= 1'b1;
                            state_q   <= S_ERROR;
                        end
                    end
                    S_NEXT: begin
                        if (shot_inc_d < {1'b0, shots_q}) begin
                            cur_shot_q  <= shot_inc_d[CNT_W-1:0];
                            fsm_start_q <= 1'b1;
                            arm_cnt_q   <= '0;
                            state_q     <= S_ARM;
                        end else if (step_inc_d < {1'b0, count_q}) begin
                            cur_step_q  <= step_inc_d[CNT_W-1:0];
                            cur_shot_q  <= '0;
                            phase_q     <= phase_q + step_q;
                            fsm_start_q <= 1'b1;
                            arm_cnt_q   <= '0;
                            state_q     <= S_ARM;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    S_ERROR: begin
                        tmo_err_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                    default: begin
                        fsm_start_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign fsm_start       = fsm_start_q;
    assign fsm_phase_shift = phase_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign timeout_err     = tmo_err_q;
    assign cur_step        = cur_step_q;
    assign cur_shot        = cur_shot_q;
    assign scenario_state  = {5'd0, state_q};

endmodule

// File: tb/tb_phase_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_scan_sequencer
//
// Drives phase_scan_sequencer with a stand-in calibration FSM that answers
// each fsm_start pulse with a trigger pulse, records every start pulse
// (phase, step, shot, width) and compares against a step/shot list derived
// directly from the scan arithmetic (phase = begin + step*increment).
// ---------------------------------------------------------------------------
module tb_phase_scan_sequencer;

    localparam int SW  = 32;
    localparam int CW  = 16;
    localparam int SPL = 4;
    localparam int TMO = 1000;

    logic          clock = 1'b0;
    logic          reset_signal;
    logic          scan_start;
    logic          scan_abort;
    logic [SW-1:0] shift_begin;
    logic [SW-1:0] shift_step;
    logic [CW-1:0] step_count;
    logic [CW-1:0] shots_per_step;
    logic          trigger_in;
    logic          fsm_start;
    logic [SW-1:0] fsm_phase_shift;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [CW-1:0] cur_step;
    logic [CW-1:0] cur_shot;
    logic [7:0]    scenario_state;

    always #5 clock = ~clock;

    phase_scan_sequencer #(
        .SHIFT_W(SW), .CNT_W(CW), .START_PULSE_LEN(SPL), .SHOT_TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset_signal(reset_signal), .scan_start(scan_start),
        .scan_abort(scan_abort), .shift_begin(shift_begin), .shift_step(shift_step),
        .step_count(step_count), .shots_per_step(shots_per_step),
        .trigger_in(trigger_in), .fsm_start(fsm_start),
        .fsm_phase_shift(fsm_phase_shift), .busy(busy), .done(done),
        .timeout_err(timeout_err), .cur_step(cur_step), .cur_shot(cur_shot),
        .scenario_state(scenario_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- stand-in calibration FSM ----------------
    bit   resp_en    = 1'b1;
    int   resp_delay = 50;
    int   resp_len   = 10;
    logic rsp_prev   = 1'b0;

    initial begin
        trigger_in = 1'b0;
        forever begin
            @(negedge clock);
            if (resp_en && fsm_start && !rsp_prev) begin
                repeat (resp_delay) @(negedge clock);
                trigger_in = 1'b1;
                repeat (resp_len) @(negedge clock);
                trigger_in = 1'b0;
            end
            rsp_prev = fsm_start;
        end
    end

    // ---------------- start-pulse monitor ----------------
    logic [SW-1:0] q_phase[$];
    int            q_step[$];
    int            q_shot[$];
    int            q_width[$];
    logic          mon_prev = 1'b0;
    int            mon_w    = 0;

    always @(negedge clock) begin
        if (fsm_start && !mon_prev) begin
            q_phase.push_back(fsm_phase_shift);
            q_step.push_back(int'(cur_step));
            q_shot.push_back(int'(cur_shot));
            mon_w = 1;
        end else if (fsm_start) begin
            mon_w++;
        end else if (mon_prev) begin
            q_width.push_back(mon_w);
        end
        mon_prev = fsm_start;
    end

    task automatic clear_mon();
        q_phase.delete();
        q_step.delete();
        q_shot.delete();
        q_width.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic start_scan(input logic [SW-1:0] b, input logic [SW-1:0] st,
                              input logic [CW-1:0] cnt, input logic [CW-1:0] sh);
        @(negedge clock);
        shift_begin    = b;
        shift_step     = st;
        step_count     = cnt;
        shots_per_step = sh;
        clear_mon();
        scan_start     = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 6000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_finished"}, 64'(busy), 64'(1'b0));
    endtask

    task automatic run_scan(input logic [SW-1:0] b, input logic [SW-1:0] st,
                            input logic [CW-1:0] cnt, input logic [CW-1:0] sh,
                            input string tag);
        start_scan(b, st, cnt, sh);
        repeat (4) @(negedge clock);
        wait_idle(tag);
        scan_start = 1'b0;
        repeat (80) @(negedge clock);
    endtask

    task automatic wait_for(input logic [7:0] code, input int step, input string tag);
        int n = 0;
        while (!(scenario_state == code && int'(cur_step) == step) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_reached"}, 64'(n < 3000), 64'(1'b1));
    endtask

    // Reference: the pulse list is every (step, shot) pair in order, with
    // phase = begin + step*increment modulo 2^SW.
    task automatic verify_scan(input logic [SW-1:0] b, input logic [SW-1:0] st,
                               input int cnt, input int sh, input string tag);
        int            shots = (sh == 0) ? 1 : sh;
        int            idx   = 0;
        logic [SW-1:0] e;
        logic [SW-1:0] last;
        check({tag, "_pulse_count"}, 64'(q_phase.size()), 64'(cnt * shots));
        for (int s = 0; s < cnt; s++) begin
            for (int k = 0; k < shots; k++) begin
                e = b + st * SW'(s);
                if (idx < q_phase.size()) begin
                    check({tag, "_phase"}, 64'(q_phase[idx]), 64'(e));
                    check({tag, "_step"},  64'(q_step[idx]),  64'(s));
                    check({tag, "_shot"},  64'(q_shot[idx]),  64'(k));
                end
                if (idx < q_width.size())
                    check({tag, "_width"}, 64'(q_width[idx]), 64'(SPL));
                idx++;
            end
        end
        last = (cnt == 0) ? b : b + st * SW'(cnt - 1);
        check({tag, "_last_phase"}, 64'(fsm_phase_shift), 64'(last));
        check({tag, "_done"},       64'(done),            64'(1'b1));
        check({tag, "_timeout"},    64'(timeout_err),     64'(1'b0));
        check({tag, "_busy"},       64'(busy),            64'(1'b0));
        check({tag, "_state"},      64'(scenario_state),  64'(8'd0));
    endtask

    typedef struct {
        logic [SW-1:0] b;
        logic [SW-1:0] st;
        logic [CW-1:0] cnt;
        logic [CW-1:0] sh;
        int            exp_pulses;
        logic [SW-1:0] exp_last;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int            n;
        int            npulse;
        logic [SW-1:0] rb;
        logic [SW-1:0] rs;
        int            rc;
        int            rh;

        tbl[0] = '{32'd100,         32'd20,   16'd3, 16'd1, 3, 32'd140};
        tbl[1] = '{32'd50,          32'd7,    16'd2, 16'd3, 6, 32'd57};
        tbl[2] = '{32'd5,           32'd1,    16'd0, 16'd2, 0, 32'd5};
        tbl[3] = '{32'd9,           32'd3,    16'd1, 16'd0, 1, 32'd9};
        tbl[4] = '{32'hFFFF_FFF0,   32'h20,   16'd2, 16'd1, 2, 32'h0000_0010};

        reset_signal   = 1'b1;
        scan_start     = 1'b0;
        scan_abort     = 1'b0;
        shift_begin    = '0;
        shift_step     = '0;
        step_count     = '0;
        shots_per_step = '0;
        repeat (3) @(negedge clock);
        reset_signal = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_fsm_start", 64'(fsm_start),       64'(1'b0));
        check("rst_phase",     64'(fsm_phase_shift), 64'(32'd0));
        check("rst_busy",      64'(busy),            64'(1'b0));
        check("rst_done",      64'(done),            64'(1'b0));
        check("rst_tmo",       64'(timeout_err),     64'(1'b0));
        check("rst_step",      64'(cur_step),        64'(16'd0));
        check("rst_shot",      64'(cur_shot),        64'(16'd0));
        check("rst_state",     64'(scenario_state),  64'(8'd0));

        // step_count = 0: done appears within a few cycles, no pulses
        start_scan(32'd7, 32'd1, 16'd0, 16'd1);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("zero_done_latency", 64'(n <= 4), 64'(1'b1));
        wait_idle("zero");
        scan_start = 1'b0;
        repeat (20) @(negedge clock);
        verify_scan(32'd7, 32'd1, 0, 1, "zero");

        // Table-driven vectors
        for (int i = 0; i < 5; i++) begin
            run_scan(tbl[i].b, tbl[i].st, tbl[i].cnt, tbl[i].sh, "tbl");
            check("tbl_pulses",  64'(q_phase.size()),  64'(tbl[i].exp_pulses));
            check("tbl_last",    64'(fsm_phase_shift), 64'(tbl[i].exp_last));
            verify_scan(tbl[i].b, tbl[i].st, int'(tbl[i].cnt), int'(tbl[i].sh), "tbl");
        end

        // Randomized scans against the reference
        for (int i = 0; i < 8; i++) begin
            rb         = $urandom;
            rs         = $urandom;
            rc         = $urandom_range(1, 4);
            rh         = $urandom_range(0, 3);
            resp_delay = $urandom_range(5, 30);
            resp_len   = $urandom_range(1, 8);
            run_scan(rb, rs, CW'(rc), CW'(rh), "rnd");
            verify_scan(rb, rs, rc, rh, "rnd");
        end
        resp_delay = 50;
        resp_len   = 10;

        // Timeout: no trigger ever arrives
        resp_en = 1'b0;
        start_scan(32'd0, 32'd1, 16'd1, 16'd1);
        wait_for(8'd3, 0, "tmo");
        n = 0;
        while (scenario_state == 8'd3 && n < 1100) begin
            @(negedge clock);
            n++;
        end
        check("tmo_wait_cycles", 64'(n),              64'(TMO));
        check("tmo_err_state",   64'(scenario_state), 64'(8'd7));
        @(negedge clock);
        check("tmo_idle",        64'(scenario_state), 64'(8'd0));
        check("tmo_flag",        64'(timeout_err),    64'(1'b1));
        check("tmo_done",        64'(done),           64'(1'b0));
        check("tmo_busy",        64'(busy),           64'(1'b0));
        scan_start = 1'b0;
        resp_en    = 1'b1;
        repeat (20) @(negedge clock);
        run_scan(32'd100, 32'd20, 16'd3, 16'd1, "tmo_clear");
        verify_scan(32'd100, 32'd20, 3, 1, "tmo_clear");

        // Abort during WAIT_END of step 1
        resp_delay = 10;
        resp_len   = 20;
        start_scan(32'd100, 32'd20, 16'd3, 16'd1);
        wait_for(8'd4, 1, "abort");
        scan_start = 1'b0;
        scan_abort = 1'b1;
        @(negedge clock);
        check("abort_state",     64'(scenario_state),  64'(8'd0));
        check("abort_fsm_start", 64'(fsm_start),       64'(1'b0));
        check("abort_busy",      64'(busy),            64'(1'b0));
        check("abort_step_hold", 64'(cur_step),        64'(16'd1));
        check("abort_phase",     64'(fsm_phase_shift), 64'(32'd120));
        check("abort_done",      64'(done),            64'(1'b0));
        scan_abort = 1'b0;
        repeat (150) @(negedge clock);
        check("abort_pulses",    64'(q_phase.size()),  64'(2));

        // Reset during ARM
        start_scan(32'd100, 32'd20, 16'd3, 16'd1);
        wait_for(8'd2, 0, "rstarm");
        scan_start   = 1'b0;
        reset_signal = 1'b1;
        @(negedge clock);
        check("rstarm_fsm_start", 64'(fsm_start),       64'(1'b0));
        check("rstarm_phase",     64'(fsm_phase_shift), 64'(32'd0));
        check("rstarm_busy",      64'(busy),            64'(1'b0));
        check("rstarm_done",      64'(done),            64'(1'b0));
        check("rstarm_tmo",       64'(timeout_err),     64'(1'b0));
        check("rstarm_step",      64'(cur_step),        64'(16'd0));
        check("rstarm_shot",      64'(cur_shot),        64'(16'd0));
        check("rstarm_state",     64'(scenario_state),  64'(8'd0));
        reset_signal = 1'b0;
        repeat (150) @(negedge clock);
        check("rstarm_pulses",    64'(q_phase.size()),  64'(1));

        // scan_start rising again while busy is ignored
        resp_delay = 20;
        resp_len   = 10;
        start_scan(32'd100, 32'd20, 16'd3, 16'd1);
        repeat (30) @(negedge clock);
        scan_start = 1'b0;
        repeat (5) @(negedge clock);
        scan_start = 1'b1;
        repeat (5) @(negedge clock);
        scan_start = 1'b0;
        wait_idle("restart");
        repeat (100) @(negedge clock);
        npulse = q_phase.size();
        check("restart_pulses", 64'(npulse), 64'(3));
        verify_scan(32'd100, 32'd20, 3, 1, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
